// File: rtl/stash_pkg.sv
// Shared types and helpers for the stopwatch stash: FSM encoding, default sizes,
// and the compare-and-wrap increment used for all ring pointers.
package stash_pkg;

  localparam int unsigned DEFAULT_DEPTH = 5;
  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2
  } stash_state_e;

  // Ring increment that works for any depth, not just powers of two
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned depth);
    return (v >= depth - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/stash_if.sv
// Stash sample/browse bus: button-side pulses in, display-side selection out.
interface stash_if
  import stash_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0]           sample_in;
  logic                       sample_valid;
  logic                       next_sample;
  logic [WIDTH-1:0]           sample_out;
  logic [$clog2(DEPTH)-1:0]   browse_idx;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       empty;
  logic                       full;

  modport master (
    output sample_in, sample_valid, next_sample,
    input  sample_out, browse_idx, count, empty, full
  );

  modport slave (
    input  sample_in, sample_valid, next_sample,
    output sample_out, browse_idx, count, empty, full
  );

endinterface

// File: rtl/stash_mem.sv
// DEPTH x WIDTH stash register file: one write port, one registered read port
// whose output is forced to zero while the stash is empty.
module stash_mem #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_clear,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || rd_clear) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/stash_ctl.sv
// Stopwatch stash controller: ring pointers, fill-state FSM and browse selection.
// Optional auto-scroll timer is built when STASH_AUTOSCROLL_EN is defined.
module stash_ctl
  import stash_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
`ifdef STASH_AUTOSCROLL_EN
  , parameter int unsigned SCROLL_TICKS = 100_000_000
`endif
) (
  input  logic   clk,
  input  logic   reset,
  stash_if.slave bus
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  stash_state_e  state;
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] oldest;
  logic [IW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] browse_idx;
  logic          empty;
  logic          full;

  logic [IW-1:0] wr_inc_c;
  logic [IW-1:0] rd_inc_c;
  logic [IW-1:0] rd_next_c;
  logic [IW-1:0] idx_c;
  logic          advance_c;

  assign wr_inc_c  = IW'(wrap_inc(32'(wr_ptr), DEPTH));
  assign rd_inc_c  = IW'(wrap_inc(32'(rd_ptr), DEPTH));
  // Stepping past the newest entry (the slot just before wr_ptr) returns to the oldest
  assign rd_next_c = (rd_inc_c == wr_ptr) ? oldest : rd_inc_c;
  assign idx_c     = (rd_ptr >= oldest) ? (rd_ptr - oldest) : (IW'(DEPTH) + rd_ptr - oldest);

`ifdef STASH_AUTOSCROLL_EN
  localparam int unsigned TW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;

  logic [TW-1:0] timer;
  logic          scroll_hit_c;

  assign scroll_hit_c = (state != ST_EMPTY) && (32'(timer) == SCROLL_TICKS - 1)
                        && !bus.sample_valid && !bus.next_sample;
  assign advance_c    = bus.next_sample | scroll_hit_c;

  always_ff @(posedge clk) begin
    if (reset || bus.sample_valid || bus.next_sample) begin
      timer <= '0;
    end else if (state != ST_EMPTY) begin
      timer <= scroll_hit_c ? '0 : timer + TW'(1);
    end
  end
`else
  assign advance_c = bus.next_sample;
`endif

  // Pointers, count and FSM; a sample always takes priority over an advance
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      wr_ptr     <= '0;
      oldest     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      browse_idx <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
    end else begin
      browse_idx <= idx_c;
      if (bus.sample_valid) begin
        wr_ptr <= wr_inc_c;
        rd_ptr <= wr_ptr;
        if (state == ST_FULL) begin
          oldest <= IW'(wrap_inc(32'(oldest), DEPTH));
        end else begin
          count <= count + CW'(1);
          empty <= 1'b0;
          if (32'(count) + 32'd1 == DEPTH) begin
            state <= ST_FULL;
            full  <= 1'b1;
          end else begin
            state <= ST_FILLING;
          end
        end
      end else if (advance_c && state != ST_EMPTY) begin
        rd_ptr <= rd_next_c;
      end
    end
  end

  stash_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.sample_valid && !reset),
    .wr_addr  (wr_ptr),
    .wr_data  (bus.sample_in),
    .rd_addr  (rd_ptr),
    .rd_clear (empty),
    .rd_data  (bus.sample_out)
  );

  assign bus.browse_idx = browse_idx;
  assign bus.count      = count;
  assign bus.empty      = empty;
  assign bus.full       = full;

endmodule

// File: tb/tb_stash_ctl.sv
// Directed self-checking bench for stash_ctl (DEPTH=5, WIDTH=8); the auto-scroll
// scenario runs on a second instance when STASH_AUTOSCROLL_EN is defined.
module tb_stash_ctl;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  stash_if #(.DEPTH(5), .WIDTH(8)) bus ();

  stash_ctl #(.DEPTH(5), .WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef STASH_AUTOSCROLL_EN
  stash_if #(.DEPTH(5), .WIDTH(8)) bus_as ();

  stash_ctl #(.DEPTH(5), .WIDTH(8), .SCROLL_TICKS(4)) dut_as (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_as)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_next();
    bus.next_sample = 1'b1;
    tick();
    bus.next_sample = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) pulse_next();
    tick();
    checks++; if (bus.sample_out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", bus.sample_out); end
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    checks++; if (bus.browse_idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", bus.browse_idx); end
  endtask

  task automatic test_browse();
    do_reset();
    send(8'h12);
    send(8'h34);
    tick();
    checks++; if (bus.count !== 3'd2) begin failures++; $display("FAIL browse_count got=%0d exp=2", bus.count); end
    checks++; if (bus.sample_out !== 8'h34) begin failures++; $display("FAIL browse_out0 got=%h exp=34", bus.sample_out); end
    checks++; if (bus.browse_idx !== 3'd1) begin failures++; $display("FAIL browse_idx0 got=%0d exp=1", bus.browse_idx); end
    checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL browse_empty got=%b exp=0", bus.empty); end
    pulse_next();
    tick();
    checks++; if (bus.sample_out !== 8'h12) begin failures++; $display("FAIL browse_out1 got=%h exp=12", bus.sample_out); end
    checks++; if (bus.browse_idx !== 3'd0) begin failures++; $display("FAIL browse_idx1 got=%0d exp=0", bus.browse_idx); end
    pulse_next();
    tick();
    checks++; if (bus.sample_out !== 8'h34) begin failures++; $display("FAIL browse_out2 got=%h exp=34", bus.sample_out); end
    checks++; if (bus.browse_idx !== 3'd1) begin failures++; $display("FAIL browse_idx2 got=%0d exp=1", bus.browse_idx); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_v;
    logic [2:0] exp_i;
    do_reset();
    for (int i = 1; i <= 6; i++) send(8'(i));
    tick();
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%b exp=1", bus.full); end
    checks++; if (bus.count !== 3'd5) begin failures++; $display("FAIL wrap_count got=%0d exp=5", bus.count); end
    checks++; if (bus.sample_out !== 8'h06) begin failures++; $display("FAIL wrap_out got=%h exp=06", bus.sample_out); end
    checks++; if (bus.browse_idx !== 3'd4) begin failures++; $display("FAIL wrap_idx got=%0d exp=4", bus.browse_idx); end
    for (int i = 0; i < 5; i++) begin
      exp_v = 8'(i + 2);
      exp_i = 3'(i);
      pulse_next();
      tick();
      checks++; if (bus.sample_out !== exp_v) begin failures++; $display("FAIL wrap_next%0d_out got=%h exp=%h", i, bus.sample_out, exp_v); end
      checks++; if (bus.browse_idx !== exp_i) begin failures++; $display("FAIL wrap_next%0d_idx got=%0d exp=%0d", i, bus.browse_idx, exp_i); end
    end
    send(8'h07);
    tick();
    checks++; if (bus.full !== 1'b1 || bus.count !== 3'd5) begin failures++; $display("FAIL wrap_stay_full got=%b/%0d exp=1/5", bus.full, bus.count); end
    checks++; if (bus.sample_out !== 8'h07) begin failures++; $display("FAIL wrap_overwrite got=%h exp=07", bus.sample_out); end
  endtask

  task automatic test_collision();
    do_reset();
    send(8'h11);
    send(8'h22);
    bus.sample_in    = 8'h77;
    bus.sample_valid = 1'b1;
    bus.next_sample  = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    bus.next_sample  = 1'b0;
    tick();
    checks++; if (bus.sample_out !== 8'h77) begin failures++; $display("FAIL coll_out got=%h exp=77", bus.sample_out); end
    checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL coll_count got=%0d exp=3", bus.count); end
    tick();
    checks++; if (bus.sample_out !== 8'h77 || bus.browse_idx !== 3'd2) begin failures++; $display("FAIL coll_no_advance got=%h/%0d exp=77/2", bus.sample_out, bus.browse_idx); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    send(8'h41);
    send(8'h42);
    send(8'h43);
    pulse_next();
    reset            = 1'b1;
    bus.sample_in    = 8'h99;
    bus.sample_valid = 1'b1;
    tick();
    reset            = 1'b0;
    bus.sample_valid = 1'b0;
    tick();
    checks++; if (bus.sample_out !== 8'h00) begin failures++; $display("FAIL rstprio_out got=%h exp=00", bus.sample_out); end
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL rstprio_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL rstprio_empty got=%b exp=1", bus.empty); end
    checks++; if (bus.browse_idx !== 3'd0) begin failures++; $display("FAIL rstprio_idx got=%0d exp=0", bus.browse_idx); end
  endtask

`ifdef STASH_AUTOSCROLL_EN
  task automatic test_autoscroll();
    logic [7:0] exp_v;
    do_reset();
    bus_as.sample_in = 8'h10; bus_as.sample_valid = 1'b1; tick();
    bus_as.sample_in = 8'h20; tick();
    bus_as.sample_valid = 1'b0;
    // Hold 20 for 4 cycles, 10 for 4 cycles, then back to 20
    for (int t = 1; t <= 9; t++) begin
      tick();
      exp_v = (t <= 4) ? 8'h20 : ((t <= 8) ? 8'h10 : 8'h20);
      checks++; if (bus_as.sample_out !== exp_v) begin failures++; $display("FAIL auto_t%0d got=%h exp=%h", t, bus_as.sample_out, exp_v); end
    end
    bus_as.next_sample = 1'b1;
    tick();
    bus_as.next_sample = 1'b0;
    for (int t = 11; t <= 15; t++) begin
      tick();
      exp_v = (t <= 14) ? 8'h10 : 8'h20;
      checks++; if (bus_as.sample_out !== exp_v) begin failures++; $display("FAIL auto_restart_t%0d got=%h exp=%h", t, bus_as.sample_out, exp_v); end
    end
  endtask
`endif

  initial begin
    reset            = 1'b1;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.next_sample  = 1'b0;
`ifdef STASH_AUTOSCROLL_EN
    bus_as.sample_in    = '0;
    bus_as.sample_valid = 1'b0;
    bus_as.next_sample  = 1'b0;
`endif
    test_reset();
    test_browse();
    test_wrap();
    test_collision();
    test_reset_priority();
`ifdef STASH_AUTOSCROLL_EN
    test_autoscroll();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
